// File: rtl/uart_tx_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer_if
// Description : Request/status handshake between a UART frame producer and
//               the transmit serializer.
// Revision    : 1.0
// ============================================================================
interface uart_tx_serializer_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;
    logic                 tx_done;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_ready,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_ready,
        output tx_done
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer
// Description : UART transmit frame serializer paced by an external bit tick.
// Revision    : 1.0
// ============================================================================
module uart_tx_serializer #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 bit_tick,
    uart_tx_serializer_if.slave  tx_bus,
    output logic                 tx_serial,
    output logic                 cnt_clear,
    output logic                 cnt_enable
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_START     = 3'd1;
    localparam logic [2:0] c_DATA      = 3'd2;
    localparam logic [2:0] c_PARITY    = 3'd3;
    localparam logic [2:0] c_STOP      = 3'd4;

    localparam logic [2:0] c_LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       c_LAST_STOP = (STOP_BITS == 2);
    localparam logic       c_ODD       = (PARITY_ODD != 0);
    localparam logic       c_PAR_EN    = (PARITY_EN != 0);

    logic [2:0]           r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [2:0]           r_bit_idx;
    logic                 r_stop_cnt;
    logic                 r_parity;
    logic                 r_serial;
    logic                 r_done;

    logic [2:0]           w_state_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [2:0]           w_bit_idx_nxt;
    logic                 w_stop_nxt;
    logic                 w_parity_nxt;
    logic                 w_serial_nxt;
    logic                 w_done_nxt;
    logic                 w_ready;
    logic                 w_accept;

    assign w_ready         = (r_state == c_IDLE);
    assign w_accept        = tx_bus.tx_start & w_ready;
    assign tx_bus.tx_ready = w_ready;
    assign tx_bus.tx_done  = r_done;
    assign tx_serial       = r_serial;
    assign cnt_clear       = w_accept;
    assign cnt_enable      = ~w_ready;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= c_IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_stop_cnt <= 1'b0;
            r_parity   <= 1'b0;
            r_serial   <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_stop_cnt <= w_stop_nxt;
            r_parity   <= w_parity_nxt;
            r_serial   <= w_serial_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_idx_nxt = r_bit_idx;
        w_stop_nxt    = r_stop_cnt;
        w_parity_nxt  = r_parity;
        w_done_nxt    = 1'b0;
        w_serial_nxt  = 1'b1;

        case (r_state)
            c_IDLE: begin
                // Parity is taken from the whole word here because the shift
                // register is consumed as the data bits go out.
                if (w_accept) begin
                    w_state_nxt   = c_START;
                    w_shift_nxt   = tx_bus.tx_data;
                    w_bit_idx_nxt = '0;
                    w_stop_nxt    = 1'b0;
                    w_parity_nxt  = (^tx_bus.tx_data) ^ c_ODD;
                end
            end
            c_START: begin
                if (bit_tick) begin
                    w_state_nxt = c_DATA;
                end
            end
            c_DATA: begin
                if (bit_tick) begin
                    w_shift_nxt   = r_shift >> 1;
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == c_LAST_BIT) begin
                        w_state_nxt = c_PAR_EN ? c_PARITY : c_STOP;
                        w_stop_nxt  = 1'b0;
                    end
                end
            end
            c_PARITY: begin
                if (bit_tick) begin
                    w_state_nxt = c_STOP;
                    w_stop_nxt  = 1'b0;
                end
            end
            c_STOP: begin
                if (bit_tick) begin
                    if (r_stop_cnt == c_LAST_STOP) begin
                        w_state_nxt = c_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_stop_nxt = r_stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase

        // The line is registered from the next state so it moves with the state.
        case (w_state_nxt)
            c_START:  w_serial_nxt = 1'b0;
            c_DATA:   w_serial_nxt = w_shift_nxt[0];
            c_PARITY: w_serial_nxt = w_parity_nxt;
            default:  w_serial_nxt = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Transmit-side frame serializer for the UART peripheral. It sits directly upstream of the shared flex counter: it drives the counter's clear and count enable, and consumes the counter's rollover flag as its bit-period tick (`bit_tick`). On each accepted request it shifts out a parallel word as a start bit, LSB-first data bits, an optional parity bit and one or two stop bits.

## Interface
- DATA_BITS, 8: data bits per frame, legal 5–8.
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd. Ignored when PARITY_EN=0.
- STOP_BITS, 1: stop bits per frame, legal 1 or 2.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- bit_tick  in  1  one-cycle bit-period strobe; connects to the counter's rollover_flag.
- tx_start  in  1  transmit request.
- tx_data  in  DATA_BITS  word to send; sampled only on acceptance.
- tx_ready  out  1  combinational; equals (state==IDLE).
- tx_done  out  1  registered; one-cycle pulse at frame end.
- tx_serial  out  1  registered serial line; idle level is 1.
- cnt_clear  out  1  combinational; equals tx_start & tx_ready.
- cnt_enable  out  1  combinational; equals (state!=IDLE).

## Operation
- States:
  - IDLE: tx_serial=1.
  - START: tx_serial=0.
  - DATA: tx_serial=shift_reg[0].
  - PARITY: tx_serial=parity bit.
  - STOP: tx_serial=1.
- Acceptance: tx_start & tx_ready at an edge latches tx_data into shift_reg, clears bit_idx, moves to START and asserts cnt_clear in the same cycle.
- Advancement: every state except IDLE advances only on an edge with bit_tick=1.
  - START→DATA.
  - DATA shifts shift_reg right and increments bit_idx. After bit DATA_BITS-1 it moves to PARITY if PARITY_EN=1, else to STOP.
  - PARITY→STOP.
  - STOP counts STOP_BITS ticks, then returns to IDLE and sets tx_done for one cycle.
- Parity: the XOR of the DATA_BITS data bits of the latched word. For odd parity the value is inverted.
- Only the low DATA_BITS of tx_data are transmitted. No upper bits exist, since the port width equals DATA_BITS.
- bit_tick in IDLE is ignored.
- tx_start while tx_ready=0 is ignored. There is no queueing and the request is not remembered.
- Changes on tx_data after acceptance do not affect the frame in flight.

## Timing
- Reset (n_rst low, asynchronous) forces state=IDLE, tx_serial=1, tx_done=0, shift_reg=0, bit_idx=0 and the stop-bit count to 0.
- Outputs during and after reset: tx_ready=1, cnt_enable=0, cnt_clear=tx_start.
- Reset mid-frame aborts immediately: the line returns to 1 and no tx_done is produced.
- tx_serial changes on the same edge as the state change. Start bit latency is one edge after acceptance.
- Each bit lasts from the tick edge that entered it to the next tick edge.
- Frame length in ticks is 1 + DATA_BITS + PARITY_EN + STOP_BITS.
- tx_done is high in the first IDLE cycle after the final stop tick. tx_ready is already 1 in that cycle, so a tx_start there is accepted.
  - Back-to-back frames: the stop bit is followed directly by the next start bit, with no extra idle cycle.
- bit_tick coinciding with acceptance is ignored. START waits for the next tick.
- cnt_enable stays high through the whole frame, including the final stop bit, and drops in the IDLE cycle after it.

## Test plan
- Reset and idle:
  - Assert n_rst low, release it, hold for 10 cycles with tx_start=0 and random bit_tick.
  - Required: tx_serial=1, tx_ready=1, tx_done=0, cnt_enable=0 throughout.
- Basic frame, defaults:
  - tx_data=0xA5, tick every 4 cycles.
  - Required line per tick: 0,1,0,1,0,0,1,0,1,1.
  - Required: exactly one tx_done pulse after the 10th tick, and cnt_clear high only in the acceptance cycle.
- Parity:
  - PARITY_EN=1, PARITY_ODD=0, tx_data=0x07. Required parity bit 1; line 0,1,1,1,0,0,0,0,0,1,1.
  - Repeat with PARITY_ODD=1. Required parity bit 0.
- Back-to-back with STOP_BITS=2:
  - Send 0x3C, then 0xC3 with tx_start held through the tx_done cycle.
  - Required: two stop-bit periods of 1, then the start bit of 0xC3 from the next edge, with no idle gap.
  - Required: tx_start pulses during the first frame are ignored.
- Mid-frame reset and late data change:
  - Change tx_data during the DATA state. Required: the transmitted word is unchanged.
  - Pulse n_rst low during bit 3. Required: tx_serial=1 immediately, state IDLE, no tx_done.
  - Required: the next tx_start sends a clean frame.
